uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, parity and framing flags.
// Define UART_RX_BREAK_DETECT_EN to add break detection (o_Break plus a BREAK_WAIT state).
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_Break,
`endif
    output logic                 o_Busy
);
    // state      | meaning
    // IDLE       | line idle, waiting for a low on the synchronised line
    // START      | validating start bit; glitch returns to IDLE
    // DATA       | sampling DATA_BITS data bits, LSB first
    // PARITY     | sampling parity bit (PARITY_MODE != 0 only)
    // STOP       | sampling stop bit(s); leaves at mid-point of the final one
    // DONE       | one-cycle delivery of byte and flags
    // BREAK_WAIT | break seen; wait for one full bit time of idle line
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK_WAIT
    } state_t;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    state_t               state;
    logic                 rx_meta, rx_sync;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_ok;
    logic                 frame_err;
    logic                 stop_idx;
    logic                 maj;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 par_bit;
`endif

    // Third sample is the live synchronised line at the decision point
    assign maj = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shift_reg    <= '0;
            parity_ok    <= 1'b1;
            frame_err    <= 1'b0;
            stop_idx     <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit      <= 1'b0;
            o_Break      <= 1'b0;
`endif
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
            o_RX_DV <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            o_Break <= 1'b0;
`endif
            if (clk_cnt == SAMP_A) samp_a <= rx_sync;
            if (clk_cnt == SAMP_B) samp_b <= rx_sync;

            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        state     <= S_START;
                        o_Busy    <= 1'b1;
                        frame_err <= 1'b0;
                        parity_ok <= 1'b1;
                        stop_idx  <= 1'b0;
                    end
                end
                S_START: begin
                    if (clk_cnt == SAMP_C && maj) begin
                        state   <= S_IDLE;
                        o_Busy  <= 1'b0;
                        clk_cnt <= '0;
                    end else if (clk_cnt == CNT_LAST) begin
                        state   <= S_DATA;
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == SAMP_C) shift_reg[bit_idx] <= maj;
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (clk_cnt == SAMP_C) begin
                        parity_ok <= ((^shift_reg) ^ maj) == (PARITY_MODE == 1);
`ifdef UART_RX_BREAK_DETECT_EN
                        par_bit   <= maj;
`endif
                    end
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == SAMP_C) begin
                        if (!maj) frame_err <= 1'b1;
                        clk_cnt <= clk_cnt + 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (!stop_idx && !maj && shift_reg == '0 &&
                            (PARITY_MODE == 0 || !par_bit)) begin
                            state   <= S_BREAK_WAIT;
                            o_Break <= 1'b1;
                            clk_cnt <= '0;
                        end else
`endif
                        if (stop_idx == STOP_LAST) begin
                            // Leave mid-bit so the next start edge is caught early
                            state   <= S_DONE;
                            clk_cnt <= '0;
                        end
                    end else if (clk_cnt == CNT_LAST) begin
                        clk_cnt  <= '0;
                        stop_idx <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    o_RX_DV      <= 1'b1;
                    o_RX_Byte    <= shift_reg;
                    o_Parity_Err <= (PARITY_MODE != 0) && !parity_ok;
                    o_Frame_Err  <= frame_err;
                    o_Busy       <= 1'b0;
                    clk_cnt      <= '0;
                    state        <= S_IDLE;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                S_BREAK_WAIT: begin
                    if (!rx_sync) begin
                        clk_cnt <= '0;
                    end else if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        o_Busy  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    o_Busy  <= 1'b0;
                    clk_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, even parity, two stop bits) at 16 clocks/bit.
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_a = 1'b1, rx_p = 1'b1, rx_s = 1'b1;
    logic       dv_a, dv_p, dv_s;
    logic [7:0] byte_a, byte_p, byte_s;
    logic       perr_a, perr_p, perr_s;
    logic       ferr_a, ferr_p, ferr_s;
    logic       busy_a, busy_p, busy_s;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_a, brk_p, brk_s;
    int         brk_cnt_a = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_a = 0, cnt_p = 0, cnt_s = 0;
    logic [7:0] last_a = 8'h00, prev_a = 8'h00;
    int base;

    always #5 clk_sys = ~clk_sys;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
        .i_Clk(clk_sys), .i_Rst_n(rst_n), .i_RX_Serial(rx_a),
        .o_RX_DV(dv_a), .o_RX_Byte(byte_a), .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk_a),
`endif
        .o_Busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2)) dut_p (
        .i_Clk(clk_sys), .i_Rst_n(rst_n), .i_RX_Serial(rx_p),
        .o_RX_DV(dv_p), .o_RX_Byte(byte_p), .o_Parity_Err(perr_p), .o_Frame_Err(ferr_p),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk_p),
`endif
        .o_Busy(busy_p));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_s (
        .i_Clk(clk_sys), .i_Rst_n(rst_n), .i_RX_Serial(rx_s),
        .o_RX_DV(dv_s), .o_RX_Byte(byte_s), .o_Parity_Err(perr_s), .o_Frame_Err(ferr_s),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk_s),
`endif
        .o_Busy(busy_s));

    // Count every cycle a pulse is high, so a stretched pulse shows up as an extra frame
    always @(negedge clk_sys) begin
        if (dv_a) begin
            cnt_a  <= cnt_a + 1;
            prev_a <= last_a;
            last_a <= byte_a;
        end
        if (dv_p) cnt_p <= cnt_p + 1;
        if (dv_s) cnt_s <= cnt_s + 1;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_s = v;
        endcase
    endtask

    task automatic bit_time(input int sel, input logic v);
        drive(sel, v);
        repeat (CPB) @(negedge clk_sys);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                              input logic par_val, input logic stop1, input int nstop);
        bit_time(sel, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(sel, data[i]);
        if (has_par) bit_time(sel, par_val);
        bit_time(sel, stop1);
        if (nstop == 2) bit_time(sel, 1'b1);
        drive(sel, 1'b1);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        settle();
        chk("rst_dv", {31'b0, dv_a}, 32'd0);
        chk("rst_byte", {24'b0, byte_a}, 32'h00);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_flags", {30'b0, perr_a, ferr_a}, 32'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk_sys);
        chk("idle_busy", {31'b0, busy_a}, 32'd0);

        // 8N1 basic frame
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
        settle();
        chk("a5_cnt", cnt_a, 32'd1);
        chk("a5_byte", {24'b0, byte_a}, 32'hA5);
        chk("a5_perr", {31'b0, perr_a}, 32'd0);
        chk("a5_ferr", {31'b0, ferr_a}, 32'd0);
        repeat (CPB) @(negedge clk_sys);

        // Even parity: 0x3C has four ones, so correct parity is 0
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1);
        settle();
        chk("par_bad_cnt", cnt_p, 32'd1);
        chk("par_bad_byte", {24'b0, byte_p}, 32'h3C);
        chk("par_bad_perr", {31'b0, perr_p}, 32'd1);
        repeat (CPB) @(negedge clk_sys);
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1);
        settle();
        chk("par_ok_cnt", cnt_p, 32'd2);
        chk("par_ok_perr", {31'b0, perr_p}, 32'd0);
        repeat (CPB) @(negedge clk_sys);

        // Start glitch of 4 cycles must be rejected
        base = cnt_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk_sys);
        rx_a = 1'b1;
        settle();
        chk("glitch_busy_mid", {31'b0, busy_a}, 32'd1);
        repeat (12) @(negedge clk_sys);
        settle();
        chk("glitch_busy_end", {31'b0, busy_a}, 32'd0);
        repeat (2 * CPB) @(negedge clk_sys);
        chk("glitch_cnt", cnt_a, base);
        chk("glitch_byte", {24'b0, byte_a}, 32'hA5);
        chk("glitch_flags", {30'b0, perr_a, ferr_a}, 32'd0);

        // Two stop bits, first one low
        send_frame(2, 8'h55, 1'b0, 1'b0, 1'b0, 2);
        settle();
        chk("stop_bad_cnt", cnt_s, 32'd1);
        chk("stop_bad_byte", {24'b0, byte_s}, 32'h55);
        chk("stop_bad_ferr", {31'b0, ferr_s}, 32'd1);
        repeat (CPB) @(negedge clk_sys);
        send_frame(2, 8'h0F, 1'b0, 1'b0, 1'b1, 2);
        settle();
        chk("stop_ok_cnt", cnt_s, 32'd2);
        chk("stop_ok_byte", {24'b0, byte_s}, 32'h0F);
        chk("stop_ok_ferr", {31'b0, ferr_s}, 32'd0);
        repeat (CPB) @(negedge clk_sys);

        // Back-to-back frames with no idle gap
        base = cnt_a;
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1);
        send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, 1);
        settle();
        chk("b2b_cnt", cnt_a, base + 2);
        chk("b2b_first", {24'b0, prev_a}, 32'h12);
        chk("b2b_second", {24'b0, last_a}, 32'h34);
        repeat (CPB) @(negedge clk_sys);

        // Reset during data bit 3 of 0xFF
        base = cnt_a;
        bit_time(0, 1'b0);
        for (int i = 0; i < 3; i++) bit_time(0, 1'b1);
        rx_a = 1'b1;
        repeat (CPB / 2) @(negedge clk_sys);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        settle();
        chk("mid_rst_byte", {24'b0, byte_a}, 32'h00);
        chk("mid_rst_busy", {31'b0, busy_a}, 32'd0);
        chk("mid_rst_dv", {31'b0, dv_a}, 32'd0);
        chk("mid_rst_byte_s", {24'b0, byte_s}, 32'h00);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk_sys);
        chk("mid_rst_cnt", cnt_a, base);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1);
        settle();
        chk("post_rst_cnt", cnt_a, base + 1);
        chk("post_rst_byte", {24'b0, byte_a}, 32'h81);
        repeat (CPB) @(negedge clk_sys);

`ifdef UART_RX_BREAK_DETECT_EN
        base = cnt_a;
        rx_a = 1'b0;
        repeat (20 * CPB) @(negedge clk_sys);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk_sys);
        settle();
        chk("brk_pulses", brk_cnt_a, 32'd1);
        chk("brk_no_dv", cnt_a, base);
        chk("brk_busy", {31'b0, busy_a}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
